// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared defaults and FSM state encoding for the PE host sequencer
package pe_pkg;

  localparam int PE_VECTOR_SIZE = 16;
  localparam int PE_L_RAM_SIZE  = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/pe_vec_ram.sv
// rtl/pe_vec_ram.sv - operand vector RAM, one write port and one registered read port
module pe_vec_ram #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // Array has no reset so it maps onto block RAM; contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read and write in the same cycle return the old word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rdata <= '0;
    else          rdata <= mem[raddr];
  end

endmodule

// File: rtl/pe_host_seq.sv
// rtl/pe_host_seq.sv - host-side sequencer: loads operand RAM, launches one PE run, captures the result
module pe_host_seq
  import pe_pkg::*;
#(
  parameter int VECTOR_SIZE    = PE_VECTOR_SIZE,
  parameter int L_RAM_SIZE     = PE_L_RAM_SIZE,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  host_we,
  input  logic [L_RAM_SIZE:0]   host_addr,
  input  logic [31:0]           host_wdata,
  input  logic                  host_go,
  output logic                  busy,
  output logic [31:0]           result,
  output logic                  result_valid,
  output logic                  err,
  output logic                  start,
  input  logic                  done,
  input  logic [L_RAM_SIZE:0]   rdaddr,
  output logic [31:0]           rddata,
  input  logic [31:0]           wrdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  assign start = (state == ST_START);

  pe_vec_ram #(
    .ADDR_W (L_RAM_SIZE + 1),
    .DEPTH  (2 * VECTOR_SIZE)
  ) u_ram (
    .aclk    (aclk),
    .aresetn (aresetn),
    .we      (host_we && !busy),
    .waddr   (host_addr),
    .wdata   (host_wdata),
    .raddr   (rdaddr),
    .rdata   (rddata)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host_go) begin
            state        <= ST_START;
            busy         <= 1'b1;
            result_valid <= 1'b0;
            err          <= 1'b0;
          end
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the terminal cycle still counts as success.
          if (done) begin
            result       <= wrdata;
            result_valid <= 1'b1;
            state        <= ST_FINISH;
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= ST_FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_host_seq.sv
// tb/tb_pe_host_seq.sv - directed and randomized checks of pe_host_seq against a memory/dot-product model
module tb_pe_host_seq;

  localparam int VS = 16;
  localparam int AW = 5;
  localparam int TO = 256;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic          host_go;
  logic          busy;
  logic [31:0]   result;
  logic          result_valid;
  logic          err;
  logic          start;
  logic          done;
  logic [AW-1:0] rdaddr;
  logic [31:0]   rddata;
  logic [31:0]   wrdata;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] model_mem [2*VS];

  always #5 aclk = ~aclk;

  pe_host_seq #(.VECTOR_SIZE(VS), .L_RAM_SIZE(4), .TIMEOUT_CYCLES(TO)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_go      (host_go),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .start        (start),
    .done         (done),
    .rdaddr       (rdaddr),
    .rddata       (rddata),
    .wrdata       (wrdata)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
    model_mem[a] = d;
  endtask

  function automatic logic [31:0] dot_model();
    logic [31:0] acc = '0;
    for (int i = 0; i < VS; i++) acc += model_mem[i] * model_mem[VS + i];
    return acc;
  endfunction

  task automatic run_pe(input int delay, input logic [31:0] wd, input string tag);
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    chk({tag, "_start_hi"}, start, 1);
    chk({tag, "_busy_hi"}, busy, 1);
    chk({tag, "_rv_clr"}, result_valid, 0);
    tick();
    chk({tag, "_start_lo"}, start, 0);
    repeat (delay) tick();
    done = 1'b1; wrdata = wd;
    tick();
    done = 1'b0;
    chk({tag, "_result"}, result, wd);
    chk({tag, "_rv"}, result_valid, 1);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy_fin"}, busy, 1);
    tick();
    chk({tag, "_busy_lo"}, busy, 0);
  endtask

  initial begin
    logic [31:0] old_word;
    logic [31:0] nd;
    logic [AW-1:0] a;
    int dly;

    aresetn = 1'b0; host_we = 0; host_addr = '0; host_wdata = '0;
    host_go = 0; done = 0; rdaddr = '0; wrdata = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_rddata", rddata, 0);
    aresetn = 1'b1;
    tick();

    // Directed dot-product run: A=1..16, B=2 everywhere
    for (int i = 0; i < VS; i++) host_write(AW'(i), 32'(i + 1));
    for (int i = 0; i < VS; i++) host_write(AW'(VS + i), 32'd2);
    chk("dot_model_272", dot_model(), 32'd272);
    run_pe(3, dot_model(), "run272");

    // Done outside WAIT is ignored
    done = 1'b1; wrdata = 32'h1234_5678;
    tick();
    done = 1'b0;
    chk("idle_done_result", result, 32'd272);
    chk("idle_done_busy", busy, 0);

    host_write(5'd5, 32'hDEAD_BEEF);
    rdaddr = 5'd5;
    tick();
    chk("rd_deadbeef", rddata, 32'hDEAD_BEEF);

    // Timeout: no done for the full WAIT window
    host_go = 1'b1; tick(); host_go = 1'b0;
    chk("to_start", start, 1);
    tick();
    repeat (TO - 1) tick();
    chk("to_err_before_last", err, 0);
    chk("to_busy_last", busy, 1);
    tick();
    chk("to_err", err, 1);
    chk("to_rv", result_valid, 0);
    chk("to_finish_busy", busy, 1);
    tick();
    chk("to_busy_lo", busy, 0);
    chk("to_err_sticky", err, 1);

    // Done on the terminal timeout cycle wins
    run_pe(TO - 1, 32'd7, "term7");

    // Writes and go while busy are dropped
    host_go = 1'b1; tick(); host_go = 1'b0;
    tick();
    host_we = 1'b1; host_addr = 5'd3; host_wdata = 32'hBAD0_0003; host_go = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busy_no_restart", start, 0);
    end
    host_we = 1'b0; host_go = 1'b0;
    done = 1'b1; wrdata = 32'd99; tick(); done = 1'b0;
    chk("busy_run_result", result, 32'd99);
    tick();
    rdaddr = 5'd3;
    tick();
    chk("busy_write_dropped", rddata, model_mem[3]);

    // Randomized read-before-write collisions and reads
    for (int k = 0; k < 12; k++) begin
      a = AW'($urandom_range(0, 2*VS - 1));
      nd = $urandom;
      old_word = model_mem[a];
      rdaddr = a; host_we = 1'b1; host_addr = a; host_wdata = nd;
      tick();
      host_we = 1'b0;
      model_mem[a] = nd;
      chk("rbw_old", rddata, old_word);
      tick();
      chk("rbw_new", rddata, nd);
    end

    // Randomized operand sets and PE latency
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2*VS; i++) host_write(AW'(i), $urandom);
      dly = $urandom_range(0, 20);
      run_pe(dly, dot_model(), "rand_run");
    end

    // Reset mid-run abandons it; memory survives
    host_go = 1'b1; tick(); host_go = 1'b0;
    tick(); tick(); tick();
    aresetn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", start, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_rv", result_valid, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rddata", rddata, 0);
    tick();
    aresetn = 1'b1;
    done = 1'b1; wrdata = 32'hFFFF_0001;
    tick();
    done = 1'b0;
    chk("post_rst_done_rv", result_valid, 0);
    chk("post_rst_done_result", result, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_start", start, 0);
    rdaddr = 5'd17;
    tick();
    chk("mem_survives_rst", rddata, model_mem[17]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
